// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root frontend and its core.
// State encoding, default widths and the normalized-range constant.
package sqrt_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ROOT_W_DEF = WIDTH_DEF / 2;

    // Lower bound of the core's normalized input range, 0.25 in 0.32 format.
    localparam logic [WIDTH_DEF-1:0] FRAC_ONE_QUARTER =
        WIDTH_DEF'(1) << (WIDTH_DEF - 2);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NORM   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DENORM = 3'd4;
    localparam logic [2:0] ST_FIX    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_DOWN = 2'd1,
        DIR_UP   = 2'd2
    } fix_dir_e;

endpackage

// File: rtl/sqrt_uint_frontend_fix.sv
// One floor-root correction decision: compares r^2 and (r+1)^2 against a.
// Holds the block's only multiplier; (r+1)^2 is derived from r^2.
module sqrt_fix_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ROOT_W = WIDTH / 2
) (
    input  logic [ROOT_W-1:0] r_i,
    input  logic [WIDTH-1:0]  a_i,
    output fix_dir_e          dir_o,
    output logic [ROOT_W:0]   rem_o
);

    logic [WIDTH-1:0] sq;
    logic [WIDTH:0]   sq_up;
    logic             over;
    logic             r_max;

    assign sq    = WIDTH'(r_i) * WIDTH'(r_i);
    assign sq_up = (WIDTH+1)'(sq) + (WIDTH+1)'({r_i, 1'b0}) + (WIDTH+1)'(1);
    assign over  = sq > a_i;
    assign r_max = &r_i;

    always_comb begin
        dir_o = DIR_HOLD;
        if (over) begin
            dir_o = DIR_DOWN;
        end else if ((sq_up <= {1'b0, a_i}) && !r_max) begin
            dir_o = DIR_UP;
        end
    end

    // Saturate so an overshooting best-effort root never reports a wrapped remainder.
    assign rem_o = over ? '0 : (ROOT_W+1)'(a_i - sq);

endmodule

// File: rtl/sqrt_uint_frontend.sv
// Integer sqrt frontend: normalizes the radicand for the Goldschmidt core,
// then denormalizes and corrects the root to the exact floor value.
module sqrt_uint_frontend
    import sqrt_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ROOT_W  = WIDTH / 2,
    parameter int MAX_FIX = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem,
    output logic              err,
    output logic              core_start,
    output logic [WIDTH-1:0]  core_d,
    input  logic [WIDTH-1:0]  core_q,
    input  logic              core_busy,
    input  logic              core_ready
);

    localparam int S_W = $clog2(WIDTH);
    localparam int C_W = $clog2(MAX_FIX + 1);

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [S_W-1:0]    s_q, s_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [ROOT_W-1:0] r_q, r_d;
    logic [C_W-1:0]    cnt_q, cnt_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [ROOT_W:0]   rem_q, rem_d;
    logic              err_q, err_d;
    logic              start_q, start_d;

    fix_dir_e          dir;
    logic [ROOT_W:0]   fix_rem;

    sqrt_fix_step #(
        .WIDTH  (WIDTH),
        .ROOT_W (ROOT_W)
    ) u_fix (
        .r_i   (r_q),
        .a_i   (a_q),
        .dir_o (dir),
        .rem_o (fix_rem)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x_d     = x_q;
        s_d     = s_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        err_d   = err_q;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    x_d = a;
                    s_d = '0;
                    if (a == '0) begin
                        root_d  = '0;
                        rem_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (x_q[WIDTH-1:WIDTH-2] == 2'b00) begin
                    x_d = x_q << 2;
                    s_d = s_q + S_W'(2);
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!core_busy) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_ready) begin
                    q_d     = core_q;
                    state_d = ST_DENORM;
                end
            end
            ST_DENORM: begin
                // Undo half the normalization shift plus the 0.32 -> integer scaling.
                r_d     = ROOT_W'(q_q >> (ROOT_W + int'(s_q[S_W-1:1])));
                cnt_d   = '0;
                state_d = ST_FIX;
            end
            ST_FIX: begin
                if (dir == DIR_HOLD || cnt_q == C_W'(MAX_FIX)) begin
                    root_d  = r_q;
                    rem_d   = fix_rem;
                    err_d   = (dir != DIR_HOLD);
                    state_d = ST_DONE;
                end else begin
                    r_d   = (dir == DIR_UP) ? r_q + ROOT_W'(1)
                                            : r_q - ROOT_W'(1);
                    cnt_d = cnt_q + C_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            x_q     <= '0;
            s_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            s_q     <= s_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign root       = root_q;
    assign rem        = rem_q;
    assign err        = err_q;
    assign core_start = start_q;
    assign core_d     = x_q;

endmodule
